uart_frame_rx: RTL and testbench

//  Receive-side deframer downstream of uart_rx. Consumes the byte stream (data + 1-cycle valid).

---
 rtl/uart_frame_rx_pkg.sv | 29 ++
 rtl/uart_idle_timer.sv | 45 ++++
 rtl/uart_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_rx_pkg.sv
// +--------------------------------------------------------------------+
// | uart_frame_rx_pkg : framing constants and state encoding for the    |
// | &&payload&& deframer.  Rev 1.0                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_frame_rx_pkg;

  localparam logic [7:0] FRAME_CHAR   = 8'h26;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_HDR2  = 4'b0010,
    ST_BODY  = 4'b0100,
    ST_TAIL2 = 4'b1000
  } state_e;

  // 9-bit sum so count+add never wraps before the capacity compare.
  function automatic logic fits(input logic [7:0] cnt, input logic [8:0] add,
                                input logic [8:0] cap);
    return ({1'b0, cnt} + add) <= cap;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_idle_timer.sv
// +--------------------------------------------------------------------+
// | uart_idle_timer : counts idle cycles, flags the LIMIT-th one.       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_idle_timer #(
  parameter int LIMIT = 100
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the same cycle always beats the limit.
  assign expired = en && !clr && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_frame_rx.sv
// +--------------------------------------------------------------------+
// | uart_frame_rx : deframes &&payload&& from a uart_rx byte stream.    |
// | Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.  Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter int MAX_LEN    = 137,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [7:0]           byte_data,
  input  logic                 byte_vld,
  output logic [MAX_LEN*8-1:0] rx_string,
  output logic [7:0]           rx_length,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_err,
  output logic [1:0]           rx_err_code
);

  localparam int          BUF_W       = MAX_LEN * 8;
  localparam int          TIMEOUT_CLK = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam logic [8:0]  CAP         = 9'(MAX_LEN);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [7:0]         count_q, count_d;
  logic [BUF_W-1:0]   string_q, string_d;
  logic [7:0]         length_q, length_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;

  logic               w_is_frame;
  logic [7:0]         w_cnt_p1;
  logic               w_expired;
  logic               w_timeout;

  assign w_is_frame = (byte_data == FRAME_CHAR);
  assign w_cnt_p1   = count_q + 8'd1;

`ifdef UART_FRAME_TIMEOUT_EN
  uart_idle_timer #(
    .LIMIT (TIMEOUT_CLK)
  ) u_idle_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (byte_vld || (state_q == ST_IDLE)),
    .en        (state_q != ST_IDLE),
    .expired   (w_expired)
  );
`else
  localparam logic [31:0] TIMEOUT_CLK_V = 32'(TIMEOUT_CLK);
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CLK_V;
  assign w_expired = 1'b0;
`endif

  assign w_timeout = w_expired && (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    count_d  = count_q;
    string_d = string_q;
    length_d = length_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;

    if (w_timeout) begin
      state_d = ST_IDLE;
      buf_d   = '0;
      count_d = '0;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end else if (byte_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (w_is_frame) state_d = ST_HDR2;
        end
        ST_HDR2: begin
          if (w_is_frame) begin
            state_d = ST_BODY;
            buf_d   = '0;
            count_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BODY: begin
          if (w_is_frame) begin
            state_d = ST_TAIL2;
          end else if (fits(count_q, 9'd1, CAP)) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (count_q == 8'(i)) buf_d[8*i +: 8] = byte_data;
            end
            count_d = w_cnt_p1;
          end else begin
            state_d = ST_IDLE;
            buf_d   = '0;
            count_d = '0;
            err_d   = 1'b1;
            code_d  = ERR_OVERFLOW;
          end
        end
        ST_TAIL2: begin
          if (w_is_frame) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            string_d = buf_q;
            length_d = count_q;
            buf_d    = '0;
            count_d  = '0;
          end else if (fits(count_q, 9'd2, CAP)) begin
            // The lone '&' was payload: commit it together with this byte.
            for (int i = 0; i < MAX_LEN; i++) begin
              if (count_q == 8'(i))  buf_d[8*i +: 8] = FRAME_CHAR;
              if (w_cnt_p1 == 8'(i)) buf_d[8*i +: 8] = byte_data;
            end
            count_d = count_q + 8'd2;
            state_d = ST_BODY;
          end else begin
            state_d = ST_IDLE;
            buf_d   = '0;
            count_d = '0;
            err_d   = 1'b1;
            code_d  = ERR_OVERFLOW;
          end
        end
        default: begin
          state_d = ST_IDLE;
          buf_d   = '0;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      count_q  <= '0;
      string_q <= '0;
      length_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      string_q <= string_d;
      length_q <= length_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign rx_string   = string_q;
  assign rx_length   = length_q;
  assign rx_busy     = (state_q != ST_IDLE);
  assign rx_done     = done_q;
  assign rx_err      = err_q;
  assign rx_err_code = code_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
// +--------------------------------------------------------------------+
// | tb_uart_frame_rx : directed scoreboard bench for uart_frame_rx.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_frame_rx;

  localparam int MAX_LEN     = 16;
  localparam int CLK_FREQ    = 1_000_000;
  localparam int TIMEOUT_US  = 40;
  localparam int TIMEOUT_CLK = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int SW          = MAX_LEN * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_vld = 1'b0;
  logic [SW-1:0] rx_string;
  logic [7:0]    rx_length;
  logic          rx_busy;
  logic          rx_done;
  logic          rx_err;
  logic [1:0]    rx_err_code;

  typedef struct {
    logic          is_err;
    logic [1:0]    code;
    logic [7:0]    len;
    logic [SW-1:0] str;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  logic [SW-1:0] good_str = '0;
  logic [7:0]    good_len = '0;
  logic [SW-1:0] prev_str = '0;
  logic [7:0]    prev_len = '0;

  uart_frame_rx #(
    .MAX_LEN    (MAX_LEN),
    .CLK_FREQ   (CLK_FREQ),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .byte_data   (byte_data),
    .byte_vld    (byte_vld),
    .rx_string   (rx_string),
    .rx_length   (rx_length),
    .rx_busy     (rx_busy),
    .rx_done     (rx_done),
    .rx_err      (rx_err),
    .rx_err_code (rx_err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] pk(input string s);
    logic [SW-1:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_data = b;
    byte_vld  = 1'b1;
    @(posedge clk); #1;
    byte_vld  = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic good_frame(input string p);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.len = 8'(p.len()); e.str = pk(p);
    sb.push_back(e);
    send_str({"&&", p, "&"});
    chk({"done_early:", p}, SW'(rx_done), SW'(1'b0));
    send(8'h26);
    chk({"done_latency:", p}, SW'(rx_done), SW'(1'b1));
    chk({"busy_fall:", p}, SW'(rx_busy), SW'(1'b0));
    good_str = e.str;
    good_len = e.len;
  endtask

  task automatic err_after(input string pre, input logic [7:0] last, input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = good_len; e.str = good_str;
    sb.push_back(e);
    send_str(pre);
    send(last);
    chk("err_pulse", SW'(rx_err), SW'(1'b1));
    chk("err_code", SW'(rx_err_code), SW'(code));
    chk("err_no_done", SW'(rx_done), SW'(1'b0));
    chk("err_busy", SW'(rx_busy), SW'(1'b0));
  endtask

  // Output monitor: pops the scoreboard on each done/err pulse and
  // checks that the result registers hold still between pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_str = '0;
      prev_len = '0;
    end else begin
      chk("done_err_exclusive", SW'(rx_done && rx_err), SW'(1'b0));
      if (rx_done || rx_err) begin
        chk("event_expected", SW'(sb.size() != 0), SW'(1'b1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("sb_kind", SW'(rx_err), SW'(mon_e.is_err));
          if (mon_e.is_err) chk("sb_code", SW'(rx_err_code), SW'(mon_e.code));
          chk("sb_length", SW'(rx_length), SW'(mon_e.len));
          chk("sb_string", rx_string, mon_e.str);
        end
      end else begin
        chk("string_stable", rx_string, prev_str);
        chk("length_stable", SW'(rx_length), SW'(prev_len));
      end
      prev_str = rx_string;
      prev_len = rx_length;
    end
  end

  initial begin
    exp_t e;
    int   waited;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_string", rx_string, '0);
    chk("rst_length", SW'(rx_length), '0);
    chk("rst_busy", SW'(rx_busy), '0);
    chk("rst_done", SW'(rx_done), '0);
    chk("rst_err", SW'(rx_err), '0);
    chk("rst_code", SW'(rx_err_code), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, busy during body, one-cycle done pulse
    send_str("&&A");
    chk("busy_in_body", SW'(rx_busy), SW'(1'b1));
    e.is_err = 1'b0; e.code = 2'b00; e.len = 8'd2; e.str = pk("AB");
    sb.push_back(e);
    send_str("B&");
    send(8'h26);
    chk("t1_done", SW'(rx_done), SW'(1'b1));
    chk("t1_busy", SW'(rx_busy), SW'(1'b0));
    good_str = e.str; good_len = e.len;
    @(posedge clk); #1;
    chk("t1_done_pulse", SW'(rx_done), SW'(1'b0));

    // Empty frame, then noise with a broken header
    good_frame("");
    send(8'h78);
    chk("noise_idle", SW'(rx_busy), SW'(1'b0));
    send(8'h26);
    chk("noise_hdr2", SW'(rx_busy), SW'(1'b1));
    send(8'h51);
    chk("noise_drop", SW'(rx_busy), SW'(1'b0));
    chk("noise_no_err", SW'(rx_err), SW'(1'b0));

    // Embedded '&' and a trailing fifth '&'
    good_frame("A&B");
    good_frame("");
    send(8'h26);
    chk("fifth_amp_hdr2", SW'(rx_busy), SW'(1'b1));
    send(8'h78);
    chk("fifth_amp_drop", SW'(rx_busy), SW'(1'b0));

    // Capacity boundaries: exact fit, single-byte overflow, two-byte overflow
    good_frame("0123456789:;<=>?");
    chk("full_length", SW'(rx_length), SW'(MAX_LEN));
    err_after("&&0123456789:;<=>?", 8'h40, 2'b01);
    good_frame("C");
    good_frame("0123456789:;<=&x");
    err_after("&&0123456789:;<=>&", 8'h78, 2'b01);
    good_frame("C");

    // Stalled frame
`ifdef UART_FRAME_TIMEOUT_EN
    e.is_err = 1'b1; e.code = 2'b10; e.len = good_len; e.str = good_str;
    sb.push_back(e);
    send_str("&&A");
    waited = 0;
    for (int n = 1; n <= TIMEOUT_CLK + 5; n++) begin
      @(posedge clk); #1;
      waited = n;
      if (rx_err) break;
    end
    chk("timeout_err", SW'(rx_err), SW'(1'b1));
    chk("timeout_cycles", SW'(waited), SW'(TIMEOUT_CLK));
    chk("timeout_code", SW'(rx_err_code), SW'(2'b10));
    chk("timeout_busy", SW'(rx_busy), SW'(1'b0));
`else
    send_str("&&A");
    waited = 0;
    repeat (TIMEOUT_CLK + 10) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("stall_busy", SW'(rx_busy), SW'(1'b1));
    chk("stall_wait", SW'(waited), SW'(TIMEOUT_CLK + 10));
    e.is_err = 1'b0; e.code = 2'b00; e.len = 8'd2; e.str = pk("AB");
    sb.push_back(e);
    send_str("B&");
    send(8'h26);
    chk("stall_done", SW'(rx_done), SW'(1'b1));
    good_str = e.str; good_len = e.len;
`endif

    // Asynchronous reset mid-body
    send_str("&&ABC");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_string", rx_string, '0);
    chk("arst_length", SW'(rx_length), '0);
    chk("arst_busy", SW'(rx_busy), '0);
    chk("arst_done", SW'(rx_done), '0);
    chk("arst_err", SW'(rx_err), '0);
    chk("arst_code", SW'(rx_err_code), '0);
    good_str = '0; good_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    good_frame("D");
    chk("post_rst_len", SW'(rx_length), SW'(8'd1));

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", SW'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
